// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing, payload type and requester indices for the CDB arbiter slice.
package cdb_arbiter_pkg;

   localparam int NUM_REQ      = 7;
   localparam int CDB_WIDTH    = 3;
   localparam int ROB_IDX_W    = 6;
   localparam int DATA_WIDTH   = 32;
   localparam int STARVE_LIMIT = 8;
   localparam int SRC_W        = $clog2(NUM_REQ);
   localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [SRC_W-1:0] {
      CDB_SRC_ALU0,
      CDB_SRC_ALU1,
      CDB_SRC_ALU2,
      CDB_SRC_MULDIV0,
      CDB_SRC_MULDIV1,
      CDB_SRC_LD0,
      CDB_SRC_LD1
   } cdb_src_e;

   typedef struct packed {
      logic [ROB_IDX_W-1:0]  rob_id;
      logic [DATA_WIDTH-1:0] data;
      logic                  exc;
   } cdb_pkt_t;

   // Requester index successor; wraps at NUM_REQ, which is not a power of two.
   function automatic logic [SRC_W-1:0] src_next(input logic [SRC_W-1:0] idx);
      return (idx == CDB_SRC_LD1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request side and CDB broadcast side of the arbiter.
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic                             flush;
   logic [ROB_IDX_W-1:0]             rob_head;
   logic [NUM_REQ-1:0]               req_valid;
   cdb_pkt_t [NUM_REQ-1:0]           req_pkt;
   logic [NUM_REQ-1:0]               req_grant;
   logic [CDB_WIDTH-1:0]             cdb_valid;
   cdb_pkt_t [CDB_WIDTH-1:0]         cdb_pkt;
   logic [CDB_WIDTH-1:0][SRC_W-1:0]  cdb_src;

   modport master (
      input  flush, rob_head, req_valid, req_pkt,
      output req_grant, cdb_valid, cdb_pkt, cdb_src
   );

   modport slave (
      output flush, rob_head, req_valid, req_pkt,
      input  req_grant, cdb_valid, cdb_pkt, cdb_src
   );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating find-first: first set bit of mask at or after start, wrapping at N.
// Latency: combinational.
// Backpressure: none; pick_any=0 when mask is empty.
module cdb_arbiter_rr_pick #(
   parameter int N = 7,
   parameter int W = 3
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] start,
   output logic [N-1:0] pick_oh,
   output logic [W-1:0] pick_idx,
   output logic         pick_any
);

   always_comb begin
      int idx;
      idx      = 0;
      pick_oh  = '0;
      pick_idx = '0;
      pick_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         if (!pick_any && mask[idx]) begin
            pick_any     = 1'b1;
            pick_oh[idx] = 1'b1;
            pick_idx     = W'(idx);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Schedules up to CDB_WIDTH unit results per cycle onto the CDB (starved first, then RR or age with CDB_AGE_PRIORITY_EN).
// Latency: req_grant combinational; granted packet on cdb_* one cycle later, valid for one cycle.
// Backpressure: losers keep req_valid asserted and are retried; flush suppresses all grants for the cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input logic           clk,
   input logic           rst,
   cdb_arbiter_if.master bus
);

   logic [SRC_W-1:0]                rr_ptr;
   logic [STARVE_W-1:0]             starve_cnt [NUM_REQ];
   logic [NUM_REQ-1:0]              elig;
   logic [NUM_REQ-1:0]              starved;
   logic [NUM_REQ-1:0]              grant;
   logic [CDB_WIDTH-1:0]            slot_vld;
   cdb_pkt_t [CDB_WIDTH-1:0]        slot_pkt;
   logic [CDB_WIDTH-1:0][SRC_W-1:0] slot_src;
   logic [CDB_WIDTH-1:0]            cdb_valid_q;
   cdb_pkt_t [CDB_WIDTH-1:0]        cdb_pkt_q;
   logic [CDB_WIDTH-1:0][SRC_W-1:0] cdb_src_q;

   assign elig = bus.req_valid & {NUM_REQ{~(rst | bus.flush)}};

   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_REQ; i++)
         starved[i] = elig[i] && (starve_cnt[i] == STARVE_W'(STARVE_LIMIT));
   end

`ifdef CDB_AGE_PRIORITY_EN
   logic [ROB_IDX_W-1:0] age [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         age[i] = bus.req_pkt[i].rob_id - bus.rob_head;
   end
`else
   logic rob_head_unused;
   assign rob_head_unused = ^bus.rob_head;
`endif

   // Slot s picks from whatever earlier slots left over; starved units drain before the normal order.
   for (genvar s = 0; s < CDB_WIDTH; s++) begin : g_stage
      logic [NUM_REQ-1:0] avail;
      logic [NUM_REQ-1:0] cand;
      logic [NUM_REQ-1:0] rr_oh;
      logic [NUM_REQ-1:0] pick_oh;
      logic [SRC_W-1:0]   start;
      logic [SRC_W-1:0]   rr_idx;
      logic [SRC_W-1:0]   pick_idx;
      logic [SRC_W-1:0]   ptr_in;
      logic [SRC_W-1:0]   ptr_out;
      logic               rr_any;
      logic               pick_any;
      logic               from_rr;

      if (s == 0) begin : g_head
         assign avail  = elig;
         assign ptr_in = rr_ptr;
      end else begin : g_tail
         assign avail  = g_stage[s-1].avail & ~g_stage[s-1].pick_oh;
         assign ptr_in = g_stage[s-1].ptr_out;
      end

      assign from_rr = ~|(avail & starved);
      assign cand    = from_rr ? avail : (avail & starved);
      assign start   = from_rr ? rr_ptr : '0;

      cdb_arbiter_rr_pick #(
         .N (NUM_REQ),
         .W (SRC_W)
      ) u_pick (
         .mask     (cand),
         .start    (start),
         .pick_oh  (rr_oh),
         .pick_idx (rr_idx),
         .pick_any (rr_any)
      );

`ifdef CDB_AGE_PRIORITY_EN
      logic [NUM_REQ-1:0]   age_oh;
      logic [SRC_W-1:0]     age_idx;
      logic                 age_any;
      logic [ROB_IDX_W-1:0] best_age;

      always_comb begin
         age_oh   = '0;
         age_idx  = '0;
         age_any  = 1'b0;
         best_age = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (avail[i] && (!age_any || age[i] < best_age)) begin
               age_any  = 1'b1;
               best_age = age[i];
               age_idx  = SRC_W'(i);
            end
         end
         age_oh[age_idx] = age_any;
      end

      assign pick_oh  = from_rr ? age_oh  : rr_oh;
      assign pick_idx = from_rr ? age_idx : rr_idx;
      assign pick_any = from_rr ? age_any : rr_any;
`else
      assign pick_oh  = rr_oh;
      assign pick_idx = rr_idx;
      assign pick_any = rr_any;
`endif

      assign ptr_out     = (from_rr && pick_any) ? src_next(pick_idx) : ptr_in;
      assign slot_vld[s] = pick_any;
      assign slot_src[s] = pick_idx;
      assign slot_pkt[s] = bus.req_pkt[pick_idx];
   end

   assign grant = elig & ~(g_stage[CDB_WIDTH-1].avail & ~g_stage[CDB_WIDTH-1].pick_oh);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         cdb_pkt_q   <= '0;
         cdb_src_q   <= '0;
         for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
      end else begin
         rr_ptr      <= g_stage[CDB_WIDTH-1].ptr_out;
         cdb_valid_q <= slot_vld;
         // Idle slots keep their last payload.
         for (int s = 0; s < CDB_WIDTH; s++) begin
            if (slot_vld[s]) begin
               cdb_pkt_q[s] <= slot_pkt[s];
               cdb_src_q[s] <= slot_src[s];
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.flush || grant[i] || !bus.req_valid[i])
               starve_cnt[i] <= '0;
            else if (starve_cnt[i] != STARVE_W'(STARVE_LIMIT))
               starve_cnt[i] <= starve_cnt[i] + 1'b1;
         end
      end
   end

   assign bus.req_grant = grant;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_pkt   = cdb_pkt_q;
   assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against a queue-based scheduling model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdb_arbiter_if bus ();

   cdb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Unit-side stimulus state.
   logic                 flush;
   logic [ROB_IDX_W-1:0] rob_head;
   logic [NUM_REQ-1:0]   pend;
   cdb_pkt_t             pk [NUM_REQ];

   // Reference model state.
   int                   m_rr;
   int                   m_cnt [NUM_REQ];
   logic [CDB_WIDTH-1:0] e_vld;
   cdb_pkt_t             e_pkt [CDB_WIDTH];
   int                   e_src [CDB_WIDTH];

   logic [NUM_REQ-1:0]   obs_grant;
   int                   d_wt  [NUM_REQ];
   int                   d_max [NUM_REQ];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef CDB_AGE_PRIORITY_EN
   function automatic int age_of(input int i);
      return (int'(pk[i].rob_id) - int'(rob_head) + (1 << ROB_IDX_W)) % (1 << ROB_IDX_W);
   endfunction
`endif

   task automatic fill(input logic [NUM_REQ-1:0] mask);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mask[i] && !pend[i]) begin
            pend[i]      = 1'b1;
            pk[i].rob_id = ROB_IDX_W'($urandom);
            pk[i].data   = $urandom;
            pk[i].exc    = ($urandom_range(0, 7) == 0);
         end
      end
   endtask

   // One clock: drive, check last edge's CDB and this cycle's grants, advance the model.
   task automatic tick();
      int sel[$];
      int cand[$];
      int n_st;
      int last_rr;
      logic [NUM_REQ-1:0] eg;
      bus.flush     = flush;
      bus.rob_head  = rob_head;
      bus.req_valid = pend;
      for (int i = 0; i < NUM_REQ; i++) bus.req_pkt[i] = pk[i];
      @(negedge clk);
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(e_vld));
      for (int s = 0; s < CDB_WIDTH; s++)
         chk($sformatf("cdb_slot%0d", s), 64'({bus.cdb_pkt[s], bus.cdb_src[s]}),
             64'({e_pkt[s], SRC_W'(e_src[s])}));
      n_st    = 0;
      last_rr = -1;
      eg      = '0;
      if (!rst && !flush) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (pend[i] && m_cnt[i] == STARVE_LIMIT) sel.push_back(i);
         n_st = sel.size();
`ifdef CDB_AGE_PRIORITY_EN
         for (int i = 0; i < NUM_REQ; i++)
            if (pend[i] && m_cnt[i] != STARVE_LIMIT) cand.push_back(i);
         while (cand.size() > 0) begin
            int b = 0;
            for (int c = 1; c < cand.size(); c++)
               if (age_of(cand[c]) < age_of(cand[b])) b = c;
            sel.push_back(cand[b]);
            cand.delete(b);
         end
`else
         for (int k = 0; k < NUM_REQ; k++) begin
            int j = (m_rr + k) % NUM_REQ;
            if (pend[j] && m_cnt[j] != STARVE_LIMIT) sel.push_back(j);
         end
`endif
      end
      while (sel.size() > CDB_WIDTH) void'(sel.pop_back());
      foreach (sel[s]) begin
         eg[sel[s]] = 1'b1;
         if (s >= n_st) last_rr = sel[s];
      end
      obs_grant = bus.req_grant;
      chk("req_grant", 64'(bus.req_grant), 64'(eg));
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pend[i] && obs_grant[i]) begin
            if (d_wt[i] > d_max[i]) d_max[i] = d_wt[i];
            d_wt[i] = 0;
         end else if (pend[i]) begin
            d_wt[i]++;
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_rr  = 0;
         e_vld = '0;
         for (int s = 0; s < CDB_WIDTH; s++) begin
            e_pkt[s] = '0;
            e_src[s] = 0;
         end
         for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
      end else begin
         e_vld = '0;
         foreach (sel[s]) begin
            e_vld[s] = 1'b1;
            e_pkt[s] = pk[sel[s]];
            e_src[s] = sel[s];
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (flush || eg[i] || !pend[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < STARVE_LIMIT) m_cnt[i]++;
         end
         if (last_rr >= 0) m_rr = (last_rr + 1) % NUM_REQ;
      end
      pend = pend & ~eg;
      if (flush && !rst) begin
         pend = '0;
         for (int i = 0; i < NUM_REQ; i++) d_wt[i] = 0;
      end
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      rob_head = '0;
      pend     = '0;
      m_rr     = 0;
      e_vld    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pk[i]    = '0;
         m_cnt[i] = 0;
         d_wt[i]  = 0;
         d_max[i] = 0;
      end
      for (int s = 0; s < CDB_WIDTH; s++) begin
         e_pkt[s] = '0;
         e_src[s] = 0;
      end
      tick();
      tick();
      chk("reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      rst = 1'b0;

      // Reset in the middle of full traffic.
      fill('1); tick();
      fill('1); tick();
      fill('1);
      rst = 1'b1;
      tick();
      chk("grant_during_rst", 64'(obs_grant), 64'd0);
      chk("cdb_valid_after_rst", 64'(bus.cdb_valid), 64'd0);
      rst = 1'b0;

      // Continuous full load from rr_ptr=0.
      fill('1); tick();
      chk("rr_cycle1", 64'(obs_grant), 64'(7'b0000111));
      fill('1); tick();
      chk("rr_cycle2", 64'(obs_grant), 64'(7'b0111000));
      chk("rr_cycle2_src", 64'(bus.cdb_src), 64'({3'd5, 3'd4, 3'd3}));
      fill('1); tick();
      chk("rr_cycle3", 64'(obs_grant), 64'(7'b1000011));

      // Sustained load: requester 6 must never wait past the starvation bound.
      for (int i = 0; i < NUM_REQ; i++) d_max[i] = 0;
      for (int c = 0; c < 20; c++) begin
         fill('1);
         tick();
      end
      chk("starve_bound_req6", 64'(d_max[6] <= STARVE_LIMIT), 64'd1);

      for (int k = 0; k < 12 && pend != '0; k++) tick();
      chk("drain", 64'(pend), 64'd0);

      // Lone requester 4.
      pend[4]      = 1'b1;
      pk[4].rob_id = 6'd5;
      pk[4].data   = 32'hDEAD;
      pk[4].exc    = 1'b0;
      tick();
      chk("single_grant", 64'(obs_grant), 64'(7'b0010000));
      chk("single_valid", 64'(bus.cdb_valid), 64'(3'b001));
      chk("single_pkt", 64'(bus.cdb_pkt[0]), 64'({6'd5, 32'hDEAD, 1'b0}));
      chk("single_src", 64'(bus.cdb_src[0]), 64'd4);
      tick();
      chk("single_one_cycle", 64'(bus.cdb_valid), 64'd0);

      // Flush with three requests pending.
      fill(7'b0101010);
      flush = 1'b1;
      tick();
      chk("flush_grant", 64'(obs_grant), 64'd0);
      chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
      flush = 1'b0;
      fill(7'b0101010);
      tick();
      chk("post_flush_grant", 64'(obs_grant), 64'(7'b0101010));
      chk("post_flush_valid", 64'(bus.cdb_valid), 64'(3'b111));

`ifdef CDB_AGE_PRIORITY_EN
      // Age order wraps around rob_head.
      rob_head = 6'd46;
      fill(7'b0001111);
      pk[0].rob_id = 6'd2;
      pk[1].rob_id = 6'd47;
      pk[2].rob_id = 6'd10;
      pk[3].rob_id = 6'd46;
      tick();
      chk("age_grant", 64'(obs_grant), 64'(7'b0001011));
      chk("age_src", 64'(bus.cdb_src), 64'({3'd0, 3'd1, 3'd3}));
      tick();
      chk("age_late", 64'(obs_grant), 64'(7'b0000100));
`endif

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 800; c++) begin
         rob_head = ROB_IDX_W'($urandom);
         fill(NUM_REQ'($urandom));
         flush = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst   = 1'b0;
      flush = 1'b0;
      pend  = '0;
      tick();

      if (n_fail != 0) $display("%0d comparisons differed", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
